life_key_ctrl: RTL and testbench
================================

LIFE_KEY_CTRL -- requirements
Module: life_key_ctrl

Interface
REQ-001 Parameter X, default 8: board width in cells.
REQ-002 Parameter Y, default 8: board height in cells.
REQ-003 Parameter LOG2X, default 3: cursor_x width.
REQ-004 Parameter LOG2Y, default 3: cursor_y width.
REQ-005 Parameter GEN_DIV, default 24: run-mode generation prescaler counter width.
REQ-006 Port clk, input, 1: clock, rising-edge.
REQ-007 Port reset, input, 1: asynchronous, active-low reset.
REQ-008 Port scan_valid, input, 1: one-cycle strobe qualifying scan_code.
REQ-009 Port scan_code, input, 8: PS/2 set-2 byte from the keyboard receiver.
REQ-010 Port keys, output, 3: registered command to the board shift register.
REQ-011 Port cursor_x, output, LOG2X: cursor column.
REQ-012 Port cursor_y, output, LOG2Y: cursor row.
REQ-013 Port running, output, 1: 1 = free-running generations, 0 = paused.
REQ-014 Port gen_step, output, 1: one-cycle strobe requesting one generation.

Function
REQ-015 Decoder FSM states IDLE, EXT, BRK, EXT_BRK; advances only on scan_valid.
REQ-016 IDLE: 0xE0 -> EXT; 0xF0 -> BRK; any other byte -> make code, stay IDLE.
REQ-017 EXT: 0xF0 -> EXT_BRK; any other byte -> extended make code, then IDLE.
REQ-018 BRK and EXT_BRK: next byte discarded (release), then IDLE.
REQ-019 Make codes: 0x29 (space) -> KEY_FLIP; 0x76 (Esc) -> KEY_CLEAR; 0x5A (Enter) -> toggle running; 0x31 (N), paused only -> single gen_step.
REQ-020 Extended make codes: 0x75 up, 0x72 down, 0x6B left, 0x74 right; all other codes are ignored.
REQ-021 Encodings from key_codes.vh: KEY_NONE=0, KEY_FLIP=1, KEY_UP=2, KEY_DOWN=3, KEY_LEFT=4, KEY_RIGHT=5, KEY_CLEAR=7.
REQ-022 keys = the decoded command for exactly one cycle, in the cycle after the scan_valid that completes it; KEY_NONE otherwise.
REQ-023 Cursor update lands in the same cycle keys shows the move command.
REQ-024 Up decrements cursor_y, down increments it; left decrements cursor_x, right increments it.
REQ-025 KEY_FLIP and KEY_CLEAR are suppressed (keys = KEY_NONE) while running = 1.
REQ-026 Prescaler: free-running GEN_DIV-bit counter, active only while running = 1.
REQ-027 Prescaler terminal count (all ones) -> gen_step = 1 for one cycle, counter wraps to 0.
REQ-028 Enter toggle clears the prescaler; first run-mode gen_step follows 2^GEN_DIV cycles later.
REQ-029 N while paused -> gen_step one cycle after the completing scan_valid; N while running is ignored.
REQ-030 scan_valid in two consecutive cycles: each byte is processed in order, with no byte lost.

Reset
REQ-031 reset low: state IDLE, keys = KEY_NONE, cursor_x = 0, cursor_y = 0, running = 0, gen_step = 0, prescaler = 0.
REQ-032 Reset mid-sequence (e.g. after 0xE0) discards the partial sequence; the next byte is decoded from IDLE.
REQ-033 Reset deassertion needs no synchronisation inside this block.

Configuration
REQ-034 Macro LIFE_CURSOR_WRAP_EN defined: cursor wraps (x: 0 -> X-1 on left, X-1 -> 0 on right; same for y with Y).
REQ-035 LIFE_CURSOR_WRAP_EN undefined: cursor saturates at 0 and X-1 / Y-1, and keys still shows the move command.

Verification
REQ-036 After reset, scan_valid with 0x29 -> keys = 1 for exactly one cycle, then 0; cursor stays (0,0).
REQ-037 Bytes E0,75 with cursor_y = 0 -> WRAP_EN: cursor_y = 7, keys = 2 one cycle; no WRAP_EN: cursor_y = 0.
REQ-038 Bytes F0,29 and E0,F0,74 -> keys stays 0, cursor unchanged, FSM back in IDLE.
REQ-039 GEN_DIV = 3, bytes 5A -> running = 1; gen_step pulses every 8 cycles; 0x29 while running -> keys stays 0.
REQ-040 Paused, byte 31 -> one gen_step pulse; running, byte 31 -> no extra pulse.
REQ-041 Byte E0, then reset low for one cycle, then byte 74 -> no move; byte is treated as unmapped make code, cursor stays (0,0).

Source files
------------

// File: rtl/life_key_ctrl.sv
// life_key_ctrl: PS/2 set-2 keyboard front end for the Life board.
// Decodes make, extended and break sequences into board commands. Owns the
// cursor position, the run/pause flag and the generation prescaler.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   scan_valid one-cycle strobe qualifying scan_code
//   scan_code  PS/2 set-2 byte from the keyboard receiver
//   keys       registered one-cycle command to the board shift register
//   cursor_x   cursor column
//   cursor_y   cursor row
//   running    1 = free-running generations, 0 = paused
//   gen_step   one-cycle strobe requesting one generation
//
// Build option: define LIFE_CURSOR_WRAP_EN to make the cursor wrap at the
// board edges. Without it, the cursor saturates at the edges.
module life_key_ctrl #(
  parameter int unsigned X       = 8,
  parameter int unsigned Y       = 8,
  parameter int unsigned LOG2X   = 3,
  parameter int unsigned LOG2Y   = 3,
  parameter int unsigned GEN_DIV = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scan_valid,
  input  logic [7:0]       scan_code,
  output logic [2:0]       keys,
  output logic [LOG2X-1:0] cursor_x,
  output logic [LOG2Y-1:0] cursor_y,
  output logic             running,
  output logic             gen_step
);

  // Command encodings shared with the board shift register
  localparam logic [2:0] KEY_NONE  = 3'd0;
  localparam logic [2:0] KEY_FLIP  = 3'd1;
  localparam logic [2:0] KEY_UP    = 3'd2;
  localparam logic [2:0] KEY_DOWN  = 3'd3;
  localparam logic [2:0] KEY_LEFT  = 3'd4;
  localparam logic [2:0] KEY_RIGHT = 3'd5;
  localparam logic [2:0] KEY_CLEAR = 3'd7;

  localparam logic [LOG2X-1:0] X_MAX = LOG2X'(X - 1);
  localparam logic [LOG2Y-1:0] Y_MAX = LOG2Y'(Y - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  state_t             r_state;
  logic [2:0]         r_keys;
  logic [LOG2X-1:0]   r_x;
  logic [LOG2Y-1:0]   r_y;
  logic               r_running;
  logic               r_gen_step;
  logic [GEN_DIV-1:0] r_presc;

  logic               w_make;
  logic               w_ext_make;
  logic [2:0]         w_key;
  logic               w_toggle;
  logic               w_single;
  logic [LOG2X-1:0]   w_x_nxt;
  logic [LOG2Y-1:0]   w_y_nxt;

  assign keys     = r_keys;
  assign cursor_x = r_x;
  assign cursor_y = r_y;
  assign running  = r_running;
  assign gen_step = r_gen_step;

  // A byte completes a make code in IDLE unless it is a prefix byte
  assign w_make     = scan_valid && (r_state == ST_IDLE) &&
                      (scan_code != 8'hE0) && (scan_code != 8'hF0);
  assign w_ext_make = scan_valid && (r_state == ST_EXT) && (scan_code != 8'hF0);

  // Command decode; board-editing keys are dropped while running
  always_comb begin
    w_key    = KEY_NONE;
    w_toggle = 1'b0;
    w_single = 1'b0;
    if (w_make) begin
      case (scan_code)
        8'h29:   if (!r_running) w_key = KEY_FLIP;
        8'h76:   if (!r_running) w_key = KEY_CLEAR;
        8'h5A:   w_toggle = 1'b1;
        8'h31:   if (!r_running) w_single = 1'b1;
        default: w_key = KEY_NONE;
      endcase
    end else if (w_ext_make) begin
      case (scan_code)
        8'h75:   w_key = KEY_UP;
        8'h72:   w_key = KEY_DOWN;
        8'h6B:   w_key = KEY_LEFT;
        8'h74:   w_key = KEY_RIGHT;
        default: w_key = KEY_NONE;
      endcase
    end
  end

  // Next cursor position, timed to land with the move command on keys
  always_comb begin
    w_x_nxt = r_x;
    w_y_nxt = r_y;
    case (w_key)
`ifdef LIFE_CURSOR_WRAP_EN
      KEY_LEFT:  w_x_nxt = (r_x == '0)    ? X_MAX : r_x - LOG2X'(1);
      KEY_RIGHT: w_x_nxt = (r_x == X_MAX) ? '0    : r_x + LOG2X'(1);
      KEY_UP:    w_y_nxt = (r_y == '0)    ? Y_MAX : r_y - LOG2Y'(1);
      KEY_DOWN:  w_y_nxt = (r_y == Y_MAX) ? '0    : r_y + LOG2Y'(1);
`else
      KEY_LEFT:  w_x_nxt = (r_x == '0)    ? r_x : r_x - LOG2X'(1);
      KEY_RIGHT: w_x_nxt = (r_x == X_MAX) ? r_x : r_x + LOG2X'(1);
      KEY_UP:    w_y_nxt = (r_y == '0)    ? r_y : r_y - LOG2Y'(1);
      KEY_DOWN:  w_y_nxt = (r_y == Y_MAX) ? r_y : r_y + LOG2Y'(1);
`endif
      default: begin
        w_x_nxt = r_x;
        w_y_nxt = r_y;
      end
    endcase
  end

  // Decoder FSM, registered outputs and generation prescaler
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_keys     <= KEY_NONE;
      r_x        <= '0;
      r_y        <= '0;
      r_running  <= 1'b0;
      r_gen_step <= 1'b0;
      r_presc    <= '0;
    end else begin
      r_keys     <= w_key;
      r_x        <= w_x_nxt;
      r_y        <= w_y_nxt;
      r_gen_step <= 1'b0;

      if (scan_valid) begin
        case (r_state)
          ST_IDLE: begin
            if (scan_code == 8'hE0)      r_state <= ST_EXT;
            else if (scan_code == 8'hF0) r_state <= ST_BRK;
          end
          ST_EXT:  r_state <= (scan_code == 8'hF0) ? ST_EXT_BRK : ST_IDLE;
          default: r_state <= ST_IDLE;  // release byte discarded
        endcase
      end

      // Enter restarts the prescaler so the first run step is a full period away
      if (w_toggle) begin
        r_running <= ~r_running;
        r_presc   <= '0;
      end else if (r_running) begin
        if (&r_presc) begin
          r_presc    <= '0;
          r_gen_step <= 1'b1;
        end else begin
          r_presc <= r_presc + GEN_DIV'(1);
        end
      end else if (w_single) begin
        r_gen_step <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_life_key_ctrl.sv
// Testbench for life_key_ctrl: table of key sequences plus hand-written
// edge, run-mode and reset-abort sequences. Every driven cycle pushes the
// expected outputs for the following cycle onto a scoreboard queue.
module tb_life_key_ctrl;

`ifdef LIFE_CURSOR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       scan_valid = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic [2:0] keys;
  logic [2:0] cursor_x;
  logic [2:0] cursor_y;
  logic       running;
  logic       gen_step;

  life_key_ctrl #(.X(8), .Y(8), .LOG2X(3), .LOG2Y(3), .GEN_DIV(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .scan_valid(scan_valid),
    .scan_code (scan_code),
    .keys      (keys),
    .cursor_x  (cursor_x),
    .cursor_y  (cursor_y),
    .running   (running),
    .gen_step  (gen_step)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [2:0] key;
    logic [2:0] cx;
    logic [2:0] cy;
    logic       run;
    logic       gs;
  } exp_t;

  typedef struct {
    logic [7:0] b0, b1, b2;
    int         n;
    logic [2:0] key;
    logic [2:0] cx, cy;
    logic       gs;
  } vec_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [2:0] ex = 3'd0;
  logic [2:0] ey = 3'd0;
  logic       erun = 1'b0;
  int         t0 = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Scoreboard consumer: compare outputs against entries due this cycle
  always @(negedge clk) begin
    if (reset) begin
      while (q.size() > 0 && q[0].due <= cyc) begin
        exp_t e;
        e = q.pop_front();
        check("due_cycle", cyc, e.due);
        check("keys", int'(keys), int'(e.key));
        check("cursor_x", int'(cursor_x), int'(e.cx));
        check("cursor_y", int'(cursor_y), int'(e.cy));
        check("running", int'(running), int'(e.run));
        check("gen_step", int'(gen_step), int'(e.gs));
      end
    end
  end

  // Drive one cycle of input; expectation applies one cycle later
  task automatic drive(input logic v, input logic [7:0] c, input logic [2:0] k,
                       input logic gs_n, input logic tog);
    exp_t e;
    logic run_before;
    @(posedge clk);
    #1;
    scan_valid = v;
    scan_code  = c;
    e.due      = cyc + 1;
    run_before = erun;
    if (tog) begin
      erun = ~erun;
      t0   = e.due;
    end
    e.key = k;
    e.cx  = ex;
    e.cy  = ey;
    e.run = erun;
    e.gs  = gs_n || (run_before && !tog && (((e.due - t0) % 8) == 0));
    q.push_back(e);
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    check("queue_drained", q.size(), 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_keys"}, int'(keys), 0);
    check({tag, "_cursor_x"}, int'(cursor_x), 0);
    check({tag, "_cursor_y"}, int'(cursor_y), 0);
    check({tag, "_running"}, int'(running), 0);
    check({tag, "_gen_step"}, int'(gen_step), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[14];
    logic [2:0] cx6, cy6;
    logic [7:0] b;
    cx6 = WRAP ? 3'd7 : 3'd0;
    cy6 = WRAP ? 3'd7 : 3'd0;
    tbl[0]  = '{8'h29, 8'h00, 8'h00, 1, 3'd1, 3'd0, 3'd0, 1'b0};
    tbl[1]  = '{8'hE0, 8'h74, 8'h00, 2, 3'd5, 3'd1, 3'd0, 1'b0};
    tbl[2]  = '{8'hE0, 8'h72, 8'h00, 2, 3'd3, 3'd1, 3'd1, 1'b0};
    tbl[3]  = '{8'hE0, 8'h6B, 8'h00, 2, 3'd4, 3'd0, 3'd1, 1'b0};
    tbl[4]  = '{8'hE0, 8'h6B, 8'h00, 2, 3'd4, cx6, 3'd1, 1'b0};
    tbl[5]  = '{8'hE0, 8'h75, 8'h00, 2, 3'd2, cx6, 3'd0, 1'b0};
    tbl[6]  = '{8'hE0, 8'h75, 8'h00, 2, 3'd2, cx6, cy6, 1'b0};
    tbl[7]  = '{8'hF0, 8'h29, 8'h00, 2, 3'd0, cx6, cy6, 1'b0};
    tbl[8]  = '{8'hE0, 8'hF0, 8'h74, 3, 3'd0, cx6, cy6, 1'b0};
    tbl[9]  = '{8'h76, 8'h00, 8'h00, 1, 3'd7, cx6, cy6, 1'b0};
    tbl[10] = '{8'h1C, 8'h00, 8'h00, 1, 3'd0, cx6, cy6, 1'b0};
    tbl[11] = '{8'hE0, 8'h11, 8'h00, 2, 3'd0, cx6, cy6, 1'b0};
    tbl[12] = '{8'h31, 8'h00, 8'h00, 1, 3'd0, cx6, cy6, 1'b1};
    tbl[13] = '{8'h29, 8'h00, 8'h00, 1, 3'd1, cx6, cy6, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    @(posedge clk);
    #1 reset = 1'b1;

    // Table: bytes of one sequence back to back, then an idle cycle
    foreach (tbl[i]) begin
      for (int j = 0; j < tbl[i].n; j++) begin
        b = (j == 0) ? tbl[i].b0 : (j == 1) ? tbl[i].b1 : tbl[i].b2;
        if (j == tbl[i].n - 1) begin
          ex = tbl[i].cx;
          ey = tbl[i].cy;
          drive(1'b1, b, tbl[i].key, tbl[i].gs, 1'b0);
        end else begin
          drive(1'b1, b, 3'd0, 1'b0, 1'b0);
        end
      end
      idle();
    end

    // Push past the right and bottom edges
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 8'hE0, 3'd0, 1'b0, 1'b0);
      ex = WRAP ? ex + 3'd1 : ((ex == 3'd7) ? ex : ex + 3'd1);
      drive(1'b1, 8'h74, 3'd5, 1'b0, 1'b0);
    end
    idle();
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 8'hE0, 3'd0, 1'b0, 1'b0);
      ey = WRAP ? ey + 3'd1 : ((ey == 3'd7) ? ey : ey + 3'd1);
      drive(1'b1, 8'h72, 3'd3, 1'b0, 1'b0);
    end
    idle();
    drain();

    // Reset in the middle of an extended sequence
    drive(1'b1, 8'hE0, 3'd0, 1'b0, 1'b0);
    idle();
    drain();
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_state("mid_reset");
    @(posedge clk);
    #1 reset = 1'b1;
    ex = 3'd0;
    ey = 3'd0;
    erun = 1'b0;
    drive(1'b1, 8'h74, 3'd0, 1'b0, 1'b0);
    idle();
    drive(1'b1, 8'h29, 3'd1, 1'b0, 1'b0);
    idle();

    // Run mode: periodic gen_step, edits and N ignored, then pause again
    drive(1'b1, 8'h5A, 3'd0, 1'b0, 1'b1);
    repeat (21) idle();
    drive(1'b1, 8'h29, 3'd0, 1'b0, 1'b0);
    repeat (2) idle();
    drive(1'b1, 8'h31, 3'd0, 1'b0, 1'b0);
    idle();
    drive(1'b1, 8'h76, 3'd0, 1'b0, 1'b0);
    repeat (2) idle();
    drive(1'b1, 8'h5A, 3'd0, 1'b0, 1'b1);
    repeat (12) idle();
    drive(1'b1, 8'h31, 3'd0, 1'b1, 1'b0);
    repeat (3) idle();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
